// File: rtl/count_bist_checker.sv
// count_bist_checker
//   Built-in self-test sequencer and checker for the synchronous counter block.
//   It drives the counter's clear and enable through a fixed CLEAR / SETTLE /
//   RUN / HOLD sequence. On every SETTLE, RUN and HOLD cycle it compares the
//   returned count against an internal reference count. Results are tallied so
//   that the test can run on silicon without an external bench.
//
//   Optional build macro: COUNT_BIST_ROLLOVER_CHECK_EN
//     defined   : each compare also checks cut_rollover against the
//                 expected wrap (cut_en && exp == MAX_COUNT)
//     undefined : cut_rollover is ignored
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous, active-high reset
//   start         in   begin a run; sampled only in IDLE
//   cut_count     in   [WIDTH-1:0] count from the counter under test
//   cut_rollover  in   rollover flag from the counter under test
//   cut_en        out  enable to the counter under test (high in RUN)
//   cut_clear     out  synchronous clear to the counter under test (high in CLEAR)
//   busy          out  high from CLEAR through HOLD
//   done          out  one-cycle pulse while in DONE
//   pass          out  result of the last run, held until the next start
//   tests_run     out  [7:0] number of compares performed
//   tests_passed  out  [7:0] number of compares that matched
//   first_fail    out  [7:0] index of the first failing compare, 8'hFF if none
module count_bist_checker #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 9,
    parameter int RUN_LEN   = 20,
    parameter int HOLD_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] cut_count,
    input  logic             cut_rollover,
    output logic             cut_en,
    output logic             cut_clear,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       tests_run,
    output logic [7:0]       tests_passed,
    output logic [7:0]       first_fail
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        RUN,
        HOLD,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_COUNT);
    localparam logic [7:0]       RUN_LAST  = 8'(RUN_LEN - 1);
    localparam logic [7:0]       HOLD_LAST = 8'(HOLD_LEN - 1);

    state_t           state;
    logic [7:0]       phase_cnt;
    logic [WIDTH-1:0] exp_cnt;

    logic compare_active;
    logic count_ok;
    logic match;
    logic [7:0] run_next;
    logic [7:0] passed_next;

    // Moore outputs decoded straight from the state register, so they drop
    // together with the state on reset.
    assign cut_clear = (state == CLEAR);
    assign cut_en    = (state == RUN);
    assign busy      = (state == CLEAR) || (state == SETTLE) ||
                       (state == RUN)   || (state == HOLD);

    assign compare_active = (state == SETTLE) || (state == RUN) || (state == HOLD);
    assign count_ok       = (cut_count == exp_cnt);

`ifdef COUNT_BIST_ROLLOVER_CHECK_EN
    logic roll_ok;
    assign roll_ok = (cut_rollover == (cut_en && (exp_cnt == MAX_V)));
    assign match   = count_ok && roll_ok;
`else
    logic unused_rollover;
    assign unused_rollover = cut_rollover;
    assign match           = count_ok;
`endif

    assign run_next    = tests_run + 8'd1;
    assign passed_next = tests_passed + {7'd0, match};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            exp_cnt      <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            tests_run    <= '0;
            tests_passed <= '0;
            first_fail   <= '1;
        end else begin
            done <= 1'b0;

            // Reference count follows the same clear/enable the counter sees,
            // so both move on the same edge.
            if (cut_clear) begin
                exp_cnt <= '0;
            end else if (cut_en) begin
                exp_cnt <= (exp_cnt == MAX_V) ? '0 : exp_cnt + WIDTH'(1);
            end

            if (compare_active) begin
                tests_run    <= run_next;
                tests_passed <= passed_next;
                if (!match && (first_fail == 8'hFF)) begin
                    first_fail <= tests_run;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= CLEAR;
                        tests_run    <= '0;
                        tests_passed <= '0;
                        first_fail   <= '1;
                        pass         <= 1'b0;
                    end
                end
                CLEAR: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    state     <= RUN;
                    phase_cnt <= '0;
                end
                RUN: begin
                    if (phase_cnt == RUN_LAST) begin
                        state     <= HOLD;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (phase_cnt == HOLD_LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        // Final compare happens on this same edge; fold it in
                        // so pass is already valid while done is high.
                        pass  <= (passed_next == run_next);
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_bist_checker.sv
// Testbench for count_bist_checker.
// The bench drives cut_count/cut_rollover from its own timeline: compare k is
// presented in the k-th cycle after CLEAR. Expected results come either from
// hand-derived table entries or from a reference that recomputes the ideal
// counter value for each compare with plain arithmetic.
module tb_count_bist_checker;

    localparam int W    = 4;
    localparam int MAXC = 9;
    localparam int RL   = 20;
    localparam int HL   = 4;
    localparam int NC   = 1 + RL + HL;

`ifdef COUNT_BIST_ROLLOVER_CHECK_EN
    localparam bit ROLL_CHK = 1'b1;
`else
    localparam bit ROLL_CHK = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] cut_count;
    logic         cut_rollover;
    logic         cut_en;
    logic         cut_clear;
    logic         busy;
    logic         done;
    logic         pass;
    logic [7:0]   tests_run;
    logic [7:0]   tests_passed;
    logic [7:0]   first_fail;

    count_bist_checker #(
        .WIDTH     (W),
        .MAX_COUNT (MAXC),
        .RUN_LEN   (RL),
        .HOLD_LEN  (HL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cut_count    (cut_count),
        .cut_rollover (cut_rollover),
        .cut_en       (cut_en),
        .cut_clear    (cut_clear),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .tests_run    (tests_run),
        .tests_passed (tests_passed),
        .first_fail   (first_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Counter response presented for each compare index.
    int vals  [NC];
    bit rolls [NC];

    typedef struct {
        string name;
        int    mode;
        int    preload;
        int    exp_ff;
        int    exp_passed;
        bit    exp_pass;
    } vec_t;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Number of enabled edges seen by the counter before compare k.
    function automatic int edges(input int k);
        if (k == 0) return 0;
        return (k - 1 < RL) ? k - 1 : RL;
    endfunction

    function automatic bit en_at(input int k);
        return (k >= 1) && (k <= RL);
    endfunction

    function automatic int ideal(input int k);
        return edges(k) % (MAXC + 1);
    endfunction

    function automatic bit ideal_roll(input int k);
        return en_at(k) && (ideal(k) == MAXC);
    endfunction

    // Counter behaviours: 0 correct, 1 wraps at 15, 2 ignores clear (preloaded),
    // 3 correct count with rollover stuck at 0, 4 correct with a spike of 13 at k=7.
    task automatic fill(input int mode, input int preload);
        for (int k = 0; k < NC; k++) begin
            int v;
            int wrapv;
            case (mode)
                1:       v = edges(k) % 16;
                2:       v = (preload + edges(k)) % (MAXC + 1);
                default: v = edges(k) % (MAXC + 1);
            endcase
            if (mode == 4 && k == 7) v = 13;
            wrapv    = (mode == 1) ? 15 : MAXC;
            vals[k]  = v;
            rolls[k] = (mode == 3) ? 1'b0 : (en_at(k) && (v == wrapv));
        end
    endtask

    task automatic model(output int ff, output int passed, output bit p);
        ff     = 255;
        passed = 0;
        for (int k = 0; k < NC; k++) begin
            bit ok;
            ok = (vals[k] == ideal(k)) && (!ROLL_CHK || (rolls[k] == ideal_roll(k)));
            if (ok) passed++;
            else if (ff == 255) ff = k;
        end
        p = (passed == NC);
    endtask

    // Entered at a negedge with the DUT idle; returns at the negedge of the
    // idle cycle following DONE.
    task automatic run_test(input string name, input int eff, input int epassed,
                            input bit epass, input bit hold, input int mid);
        int bad;
        bit e_clear, e_en, e_busy, e_done;
        bad   = 0;
        start = 1'b1;
        for (int n = 1; n <= 3 + NC; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1 && !hold) start = 1'b0;
            if (mid >= 0 && n == 2 + mid) start = 1'b1;
            if (mid >= 0 && n == 3 + mid) start = 1'b0;
            if (n >= 2 && n <= 1 + NC) begin
                cut_count    = W'(vals[n-2]);
                cut_rollover = rolls[n-2];
            end else begin
                cut_count    = W'($urandom);
                cut_rollover = 1'($urandom);
            end
            e_clear = (n == 1);
            e_en    = (n >= 3) && (n <= 2 + RL);
            e_busy  = (n <= 1 + NC);
            e_done  = (n == 2 + NC);
            if (cut_clear !== e_clear || cut_en !== e_en ||
                busy !== e_busy || done !== e_done) begin
                bad++;
            end
            if (n == 2 + NC) begin
                check({name, ".tests_run"}, int'(tests_run), NC);
                check({name, ".tests_passed"}, int'(tests_passed), epassed);
                check({name, ".first_fail"}, int'(first_fail), eff);
                check({name, ".pass"}, int'(pass), int'(epass));
            end
        end
        check({name, ".timeline_bad_cycles"}, bad, 0);
    endtask

    vec_t tbl [5];

    initial begin
        int ff, pc;
        bit pa;

        tbl[0] = '{"correct", 0, 0, 255, 25, 1'b1};
        tbl[1] = '{"wrap15",  1, 0, ROLL_CHK ? 10 : 11, ROLL_CHK ? 10 : 11, 1'b0};
        tbl[2] = '{"noclear", 2, 5, 0, 0, 1'b0};
        tbl[3] = '{"roll0",   3, 0, ROLL_CHK ? 10 : 255, ROLL_CHK ? 23 : 25, !ROLL_CHK};
        tbl[4] = '{"spike",   4, 0, 7, 24, 1'b0};

        rst          = 1'b1;
        start        = 1'b0;
        cut_count    = '0;
        cut_rollover = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.cut_en", int'(cut_en), 0);
        check("rst.cut_clear", int'(cut_clear), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.pass", int'(pass), 0);
        check("rst.tests_run", int'(tests_run), 0);
        check("rst.tests_passed", int'(tests_passed), 0);
        check("rst.first_fail", int'(first_fail), 255);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven counter behaviours
        for (int i = 0; i < 5; i++) begin
            fill(tbl[i].mode, tbl[i].preload);
            run_test(tbl[i].name, tbl[i].exp_ff, tbl[i].exp_passed,
                     tbl[i].exp_pass, 1'b0, -1);
        end

        // start pulsed while busy is ignored
        fill(0, 0);
        run_test("mid_start", 255, 25, 1'b1, 1'b0, 5);

        // start held high: second run begins right after DONE
        fill(1, 0);
        run_test("held_a", ROLL_CHK ? 10 : 11, ROLL_CHK ? 10 : 11, 1'b0, 1'b1, -1);
        fill(0, 0);
        run_test("held_b", 255, 25, 1'b1, 1'b0, -1);

        // Reset in the middle of RUN
        fill(0, 0);
        start = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n >= 2) begin
                cut_count    = W'(vals[n-2]);
                cut_rollover = rolls[n-2];
            end
        end
        check("mid_rst.pre_tests_run", int'(tests_run), 5);
        check("mid_rst.pre_cut_en", int'(cut_en), 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst.cut_en", int'(cut_en), 0);
        check("mid_rst.busy", int'(busy), 0);
        check("mid_rst.tests_run", int'(tests_run), 0);
        check("mid_rst.first_fail", int'(first_fail), 255);
        rst = 1'b0;
        run_test("after_rst", 255, 25, 1'b1, 1'b0, -1);

        // Randomised corruptions checked against the reference
        for (int r = 0; r < 10; r++) begin
            int nbad;
            fill(0, 0);
            nbad = $urandom_range(0, 3);
            for (int i = 0; i < nbad; i++) begin
                int k;
                k = $urandom_range(0, NC - 1);
                if ($urandom_range(0, 1) == 1) vals[k] = $urandom_range(0, 15);
                else rolls[k] = !rolls[k];
            end
            model(ff, pc, pa);
            run_test($sformatf("rand%0d", r), ff, pc, pa, 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
